// File: rtl/mux_sel_sequencer.sv
// Walks an external 8:1 mux through every select value, waits for the mux output
// to settle, and streams the sampled bits out LSB first with a valid/ready/last handshake.
module mux_sel_sequencer #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3,
    parameter int DWELL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] mux_in,
    output logic [SEL_W-1:0] mux_sel,
    input  logic             mux_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_data,
    output logic             ser_last,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        EMIT   = 2'd2
    } state_t;

    localparam logic [3:0]       DWELL_CNT = 4'(DWELL);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(WIDTH - 1);

    state_t             state_reg, state_next;
    logic [3:0]         cnt_reg, cnt_next;
    logic [WIDTH-1:0]   mux_in_reg, mux_in_next;
    logic [SEL_W-1:0]   sel_reg, sel_next;
    logic               valid_reg, valid_next;
    logic               data_reg, data_next;
    logic               last_reg, last_next;
    logic               busy_reg, busy_next;
    logic               load_fire;

    // A new word may also be taken on the final-bit handshake so words run back to back.
    // Gating with rst_n keeps load_ready low for the whole time reset is held.
    assign load_ready = rst_n & ((state_reg == IDLE) |
                                 ((state_reg == EMIT) & last_reg & ser_ready));
    assign load_fire  = load_valid & load_ready;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        mux_in_next = mux_in_reg;
        sel_next    = sel_reg;
        valid_next  = valid_reg;
        data_next   = data_reg;
        last_next   = last_reg;

        case (state_reg)
            IDLE: begin
                if (load_fire) begin
                    mux_in_next = load_data;
                    sel_next    = '0;
                    cnt_next    = DWELL_CNT;
                    state_next  = SETTLE;
                end
            end
            SETTLE: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    data_next  = mux_out;
                    valid_next = 1'b1;
                    last_next  = (sel_reg == SEL_LAST);
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (ser_ready) begin
                    valid_next = 1'b0;
                    if (!last_reg) begin
                        sel_next   = sel_reg + SEL_W'(1);
                        cnt_next   = DWELL_CNT;
                        state_next = SETTLE;
                    end else begin
                        last_next = 1'b0;
                        if (load_fire) begin
                            mux_in_next = load_data;
                            sel_next    = '0;
                            cnt_next    = DWELL_CNT;
                            state_next  = SETTLE;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            mux_in_reg <= '0;
            sel_reg    <= '0;
            valid_reg  <= 1'b0;
            data_reg   <= 1'b0;
            last_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            mux_in_reg <= mux_in_next;
            sel_reg    <= sel_next;
            valid_reg  <= valid_next;
            data_reg   <= data_next;
            last_reg   <= last_next;
            busy_reg   <= busy_next;
        end
    end

    assign mux_in    = mux_in_reg;
    assign mux_sel   = sel_reg;
    assign ser_valid = valid_reg;
    assign ser_data  = data_reg;
    assign ser_last  = last_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Scoreboard bench: accepted loads queue their expected bit stream; a negedge monitor
// pops and compares on every serial handshake, alongside directed timing/reset checks.
module tb_mux_sel_sequencer;

    localparam int W  = 8;
    localparam int SW = 3;
    localparam int D  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [W-1:0]  load_data = '0;
    logic [W-1:0]  mux_in;
    logic [SW-1:0] mux_sel;
    logic          mux_out;
    logic          ser_valid;
    logic          ser_ready = 1'b0;
    logic          ser_data;
    logic          ser_last;
    logic          busy;

    mux_sel_sequencer #(.WIDTH(W), .SEL_W(SW), .DWELL(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .mux_in(mux_in), .mux_sel(mux_sel), .mux_out(mux_out),
        .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_data(ser_data),
        .ser_last(ser_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // The 8:1 mux the sequencer drives
    assign mux_out = mux_in[mux_sel];

    typedef struct packed {
        logic          d;
        logic          l;
        logic [SW-1:0] s;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [W-1:0]  cur_word = '0;
    bit            rnd_ready = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: mux_in stability, stall hold, handshake scoreboard, load capture
    initial begin : monitor
        bit            prev_stall;
        logic          sv_d, sv_l;
        logic [SW-1:0] sv_s;
        exp_t          e;
        prev_stall = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0;
            end else begin
                if (busy) chk("mux_in_stable", mux_in, cur_word);
                if (prev_stall) begin
                    chk("hold_valid", ser_valid, 1);
                    chk("hold_data", ser_data, sv_d);
                    chk("hold_last", ser_last, sv_l);
                    chk("hold_sel", mux_sel, sv_s);
                end
                if (ser_valid && ser_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_bit: got data %0b with empty scoreboard at %0t", ser_data, $time);
                    end else begin
                        e = sb.pop_front();
                        chk("ser_data", ser_data, e.d);
                        chk("ser_last", ser_last, e.l);
                        chk("bit_sel", mux_sel, e.s);
                    end
                end
                prev_stall = ser_valid && !ser_ready;
                sv_d = ser_data;
                sv_l = ser_last;
                sv_s = mux_sel;
                if (load_valid && load_ready) begin
                    cur_word = load_data;
                    for (int i = 0; i < W; i++)
                        sb.push_back('{d: load_data[i], l: (i == W-1), s: SW'(i)});
                end
            end
        end
    end

    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) ser_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic do_load(input logic [W-1:0] w, output bit was_busy);
        bit acc;
        acc = 0;
        was_busy = 0;
        load_valid = 1'b1;
        load_data  = w;
        for (int k = 0; k < 2000 && !acc; k++) begin
            @(negedge clk);
            acc = load_ready;
        end
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL load_timeout: got no load_ready expected accept of %0h", w);
        end
        was_busy = busy;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (busy && cyc < 5000);
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: got busy=1 expected 0 after %0d cycles", cyc);
        end
    endtask

    task automatic wait_sel_valid(input logic [SW-1:0] s);
        int c;
        c = 0;
        while (!(ser_valid && mux_sel == s) && c < 500) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (c >= 500) begin
            n_cmp++;
            n_err++;
            $display("FAIL sel_timeout: got sel %0d expected valid at sel %0d", mux_sel, s);
        end
    endtask

    initial begin : stim
        bit dummy, b2b;
        int c, cyc;

        // Reset state
        #12;
        chk("rst_mux_in", mux_in, 0);
        chk("rst_sel", mux_sel, 0);
        chk("rst_valid", ser_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_load_ready", load_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_load_ready", load_ready, 1);
        @(posedge clk); #1;
        ser_ready = 1'b1;

        // 8'h96, ready high: first valid DWELL cycles after load, word time W*(D+1)
        do_load(8'h96, dummy);
        c = 0;
        while (!ser_valid && c < 100) begin
            @(posedge clk); #1; c++;
        end
        chk("first_valid_latency", c, D);
        chk("first_bit_sel", mux_sel, 0);
        wait_idle(cyc);
        chk("word_time", c + cyc, W * (D + 1));
        chk("idle_sel_no_wrap", mux_sel, W - 1);
        chk("idle_load_ready", load_ready, 1);

        // 8'hFF, stall 6 cycles on bit 3
        do_load(8'hFF, dummy);
        wait_sel_valid(3'd3);
        ser_ready = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            chk("stall_valid", ser_valid, 1);
            chk("stall_data", ser_data, 1);
            chk("stall_sel", mux_sel, 3);
            chk("stall_load_ready", load_ready, 0);
        end
        ser_ready = 1'b1;
        wait_idle(cyc);

        // Back-to-back words 8'h0F then 8'hF0
        do_load(8'h0F, dummy);
        do_load(8'hF0, b2b);
        chk("b2b_accept_in_emit", b2b, 1);
        chk("b2b_sel_restart", mux_sel, 0);
        chk("b2b_busy", busy, 1);
        wait_idle(cyc);

        // Reset mid-word at sel 5
        do_load(8'h5A, dummy);
        wait_sel_valid(3'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mux_in", mux_in, 0);
        chk("mid_rst_sel", mux_sel, 0);
        chk("mid_rst_valid", ser_valid, 0);
        chk("mid_rst_data", ser_data, 0);
        chk("mid_rst_last", ser_last, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_load_ready", load_ready, 0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_load_ready", load_ready, 1);
        @(posedge clk); #1;
        do_load(8'h01, dummy);
        wait_sel_valid(3'd0);
        chk("after_rst_first_bit", ser_data, 1);
        wait_idle(cyc);

        // load_valid pulses while busy are ignored
        do_load(8'hC3, dummy);
        repeat (3) begin
            @(posedge clk); #1;
            load_valid = 1'b1;
            load_data  = W'($urandom);
            @(posedge clk); #1;
            load_valid = 1'b0;
        end
        chk("ignored_load_mux_in", mux_in, 8'hC3);
        wait_idle(cyc);

        // Randomized words with random backpressure
        rnd_ready = 1;
        for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            do_load(W'($urandom), dummy);
        end
        rnd_ready = 0;
        ser_ready = 1'b1;
        wait_idle(cyc);

        c = 0;
        while (sb.size() != 0 && c < 1000) begin
            @(posedge clk); #1; c++;
        end
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
- Sequencer placed around an 8:1 mux (`mux_8to1`).
- Accepts a parallel word through a valid/ready load handshake.
- Drives the mux data and select inputs, stepping `sel` from 0 to WIDTH-1.
- Samples the mux output after a programmable settle time and presents each bit as an LSB-first serial stream with a valid/ready/last handshake.

Parameters:
- WIDTH, 8, word width and mux input count; must be a power of 2, at least 2.
- SEL_W, 3, select width; must equal log2(WIDTH).
- DWELL, 1, cycles `mux_sel` is held stable before `mux_out` is sampled; range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- load_valid  input  1  upstream word available
- load_ready  output  1  sequencer can accept a word
- load_data  input  WIDTH  word to serialise
- mux_in  output  WIDTH  drives the mux `in` port
- mux_sel  output  SEL_W  drives the mux `sel` port
- mux_out  input  1  mux `out` port return
- ser_valid  output  1  serial bit available
- ser_ready  input  1  downstream accepts the bit
- ser_data  output  1  sampled bit
- ser_last  output  1  marks bit WIDTH-1 of the word
- busy  output  1  high whenever the state is not IDLE

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- While `rst_n` is low, all of the following are 0 immediately, independent of `clk`: `mux_in`, `mux_sel`, `ser_valid`, `ser_data`, `ser_last`, `busy`, the dwell counter, and `load_ready`. State is IDLE.
- Once `rst_n` is deasserted, `load_ready` is 1 on the first IDLE cycle.
- State machine:
  - IDLE: `load_ready` = 1. On `load_valid` & `load_ready` at edge T0: `mux_in` <= `load_data`, `mux_sel` <= 0, dwell counter <= DWELL, go to SETTLE.
  - SETTLE: dwell counter decrements each cycle. On the edge where the counter is 1: `ser_data` <= `mux_out`, `ser_valid` <= 1, `ser_last` <= (`mux_sel` == WIDTH-1), go to EMIT.
  - EMIT: `ser_valid`, `ser_data` and `ser_last` are held stable until `ser_ready`. On handshake:
    - If `ser_last` = 0: `mux_sel` <= `mux_sel` + 1, counter <= DWELL, `ser_valid` <= 0, go to SETTLE.
    - If `ser_last` = 1: `ser_valid` <= 0, `ser_last` <= 0, go to IDLE, unless a new load occurs in the same cycle (see below).
- Latency: the first `ser_valid` rises at edge T0+DWELL. Each following bit takes DWELL cycles after the previous handshake. Minimum word time is WIDTH*(DWELL+1) cycles with `ser_ready` tied high.
- Back-to-back loads: `load_ready` is also 1 in EMIT when `ser_last` & `ser_ready`.
  - A load taken in that cycle takes priority over the return to IDLE.
  - `mux_in` and `mux_sel` are reloaded and the state goes to SETTLE, so there are no idle cycles between words.
- Stability: `mux_in` is constant for the whole word and changes only on an accepted load. `mux_sel` changes only on the transitions above and never skips a value.
- Wrap: `mux_sel` stays at WIDTH-1 after the last bit and never wraps to 0 except by a new load.
- Backpressure: `ser_ready` low in EMIT stalls indefinitely with no change to any output.
- `load_valid` is ignored whenever `load_ready` = 0, with no side effect.
- Reset mid-word: the word is discarded with no partial output after reset. The next load restarts at `mux_sel` = 0.
- `busy` = (state != IDLE), registered alongside the state.

Test Plan:
- Reset, then load 8'b1001_0110 with DWELL=1 and `ser_ready`=1 → `mux_sel` steps 0..7 and `ser_data` sequence is 0,1,1,0,1,0,0,1. `ser_last` is high only on the 8th bit. `ser_valid` first rises 1 cycle after the load.
- DWELL=4, load 8'hA5 → each `mux_sel` value is held 4 cycles before `ser_valid`. Bits are 1,0,1,0,0,1,0,1. Total word time is 40 cycles.
- Load 8'hFF, hold `ser_ready`=0 for 6 cycles on bit 3 → `ser_valid`=1, `ser_data`=1 and `mux_sel`=3 stay constant for 6 cycles. `load_ready`=0 throughout.
- Two words back-to-back (8'h0F then 8'hF0), `load_valid` held high → the second load is accepted in the cycle of the last-bit handshake. `mux_sel` goes 7 → 0 with no IDLE cycle. Stream is 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1.
- Assert `rst_n`=0 mid-word at `mux_sel`=5 → all outputs are 0 immediately. After release, `load_ready`=1. Loading 8'h01 yields a first bit of 1 with `mux_sel`=0.
- `load_valid` pulses while `busy`=1 → ignored. `mux_in` stays at the original word until the word completes.
